// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: valid-qualified 3-stage multiply-add / frame accumulator.
// Mode 0 emits A*B+C per beat; mode 1 sums A*B over a frame with saturation.
module mac_pipe_acc #(
   parameter int P      = 8,
   parameter int ACC_W  = 24,
   parameter bit SIGNED = 1'b0
) (
   input  logic             C,
   input  logic             RST,
   input  logic             IN_VALID,
   input  logic             MODE,
   input  logic             FIRST,
   input  logic             LAST,
   input  logic [P-1:0]     A1,
   input  logic [P-1:0]     B1,
   input  logic [P-1:0]     C1,
   output logic             OUT_VALID,
   output logic [ACC_W-1:0] DATA_OUT,
   output logic             OVF
);

   logic                    v1_r, mode1_r, first1_r, last1_r;
   logic [P-1:0]            a1_r, b1_r, c1_r;
   logic                    v2_r, mode2_r, first2_r, last2_r;
   logic signed [2*P-1:0]   prod2_r;
   logic signed [P-1:0]     c2_r;
   logic [2*P-1:0]          a_x_s, b_x_s;
   logic [ACC_W-1:0]        prod_ext_s, c_ext_s, base_s, sat_val_s, acc_next_s, res_s;
   logic [ACC_W:0]          sum_s;
   logic                    sat_s, fovf_next_s, ovf_s, emit_s;
   logic [ACC_W-1:0]        acc_r;
   logic                    frame_ovf_r;
   logic                    v3_r, ovf3_r;
   logic [ACC_W-1:0]        res3_r;

   // Guard bit for the ACC_W+1 wide saturation sum: sign copy or zero.
   function automatic logic ext_bit(input logic [ACC_W-1:0] x);
      if (SIGNED) begin
         return x[ACC_W-1];
      end else begin
         return 1'b0;
      end
   endfunction

   // Stage 1: capture the input beat.
   always_ff @(posedge C) begin
      if (RST) begin
         v1_r     <= 1'b0;
         mode1_r  <= 1'b0;
         first1_r <= 1'b0;
         last1_r  <= 1'b0;
         a1_r     <= {P{1'b0}};
         b1_r     <= {P{1'b0}};
         c1_r     <= {P{1'b0}};
      end else begin
         v1_r     <= IN_VALID;
         mode1_r  <= MODE;
         first1_r <= FIRST;
         last1_r  <= LAST;
         a1_r     <= A1;
         b1_r     <= B1;
         c1_r     <= C1;
      end
   end

   // Operands widened to 2P so the low 2P product bits are right for either signedness.
   assign a_x_s = {{P{SIGNED & a1_r[P-1]}}, a1_r};
   assign b_x_s = {{P{SIGNED & b1_r[P-1]}}, b1_r};

   // Stage 2: product register.
   always_ff @(posedge C) begin
      if (RST) begin
         v2_r     <= 1'b0;
         mode2_r  <= 1'b0;
         first2_r <= 1'b0;
         last2_r  <= 1'b0;
         prod2_r  <= {(2*P){1'b0}};
         c2_r     <= {P{1'b0}};
      end else begin
         v2_r     <= v1_r;
         mode2_r  <= mode1_r;
         first2_r <= first1_r & mode1_r;
         last2_r  <= last1_r & mode1_r;
         prod2_r  <= a_x_s * b_x_s;
         c2_r     <= c1_r;
      end
   end

   // Extend product and addend to the accumulator width.
   always_comb begin
      if (SIGNED) begin
         prod_ext_s = ACC_W'(prod2_r);
         c_ext_s    = ACC_W'(c2_r);
      end else begin
         prod_ext_s = ACC_W'($unsigned(prod2_r));
         c_ext_s    = ACC_W'($unsigned(c2_r));
      end
   end

   // Stage 3 datapath: multiply-add or saturating accumulate.
   always_comb begin
      base_s      = {ACC_W{1'b0}};
      sum_s       = {(ACC_W+1){1'b0}};
      sat_s       = 1'b0;
      sat_val_s   = {ACC_W{1'b1}};
      acc_next_s  = acc_r;
      fovf_next_s = frame_ovf_r;
      res_s       = {ACC_W{1'b0}};
      ovf_s       = 1'b0;
      emit_s      = 1'b0;
      if (mode2_r) begin
         if (first2_r) begin
            base_s = {ACC_W{1'b0}};
         end else begin
            base_s = acc_r;
         end
         sum_s = {ext_bit(base_s), base_s} + {ext_bit(prod_ext_s), prod_ext_s};
         // Signed overflow shows up as the guard bit disagreeing with the result MSB.
         if (SIGNED) begin
            sat_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
            if (sum_s[ACC_W]) begin
               sat_val_s = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
               sat_val_s = {1'b0, {(ACC_W-1){1'b1}}};
            end
         end else begin
            sat_s     = sum_s[ACC_W];
            sat_val_s = {ACC_W{1'b1}};
         end
         if (sat_s) begin
            acc_next_s = sat_val_s;
         end else begin
            acc_next_s = sum_s[ACC_W-1:0];
         end
         fovf_next_s = (frame_ovf_r & ~first2_r) | sat_s;
         res_s       = acc_next_s;
         ovf_s       = fovf_next_s;
         emit_s      = last2_r;
      end else begin
         res_s  = prod_ext_s + c_ext_s;
         ovf_s  = 1'b0;
         emit_s = 1'b1;
      end
   end

   // Stage 3 registers: result, accumulator and sticky frame overflow.
   always_ff @(posedge C) begin
      if (RST) begin
         v3_r        <= 1'b0;
         res3_r      <= {ACC_W{1'b0}};
         ovf3_r      <= 1'b0;
         acc_r       <= {ACC_W{1'b0}};
         frame_ovf_r <= 1'b0;
      end else begin
         v3_r   <= v2_r & emit_s;
         res3_r <= res_s;
         ovf3_r <= ovf_s;
         if (v2_r & mode2_r) begin
            acc_r       <= acc_next_s;
            frame_ovf_r <= fovf_next_s;
         end
      end
   end

   // Output registers; data and flag hold between results.
   always_ff @(posedge C) begin
      if (RST) begin
         OUT_VALID <= 1'b0;
         DATA_OUT  <= {ACC_W{1'b0}};
         OVF       <= 1'b0;
      end else begin
         OUT_VALID <= v3_r;
         if (v3_r) begin
            DATA_OUT <= res3_r;
            OVF      <= ovf3_r;
         end
      end
   end

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Bench for mac_pipe_acc: three configurations share one stimulus stream and
// are compared against an arithmetic reference model of the expected results.
module tb_mac_pipe_acc;

   logic C = 1'b0;
   always #5 C = ~C;

   logic RST, IN_VALID, MODE, FIRST, LAST;
   logic [7:0] A1, B1, C1;
   logic ov0, ov1, ov2, of0, of1, of2;
   logic [23:0] d0, d2;
   logic [15:0] d1;

   mac_pipe_acc #(.P(8), .ACC_W(24), .SIGNED(1'b0)) u0 (
      .C(C), .RST(RST), .IN_VALID(IN_VALID), .MODE(MODE), .FIRST(FIRST), .LAST(LAST),
      .A1(A1), .B1(B1), .C1(C1), .OUT_VALID(ov0), .DATA_OUT(d0), .OVF(of0));
   mac_pipe_acc #(.P(8), .ACC_W(16), .SIGNED(1'b0)) u1 (
      .C(C), .RST(RST), .IN_VALID(IN_VALID), .MODE(MODE), .FIRST(FIRST), .LAST(LAST),
      .A1(A1), .B1(B1), .C1(C1), .OUT_VALID(ov1), .DATA_OUT(d1), .OVF(of1));
   mac_pipe_acc #(.P(8), .ACC_W(24), .SIGNED(1'b1)) u2 (
      .C(C), .RST(RST), .IN_VALID(IN_VALID), .MODE(MODE), .FIRST(FIRST), .LAST(LAST),
      .A1(A1), .B1(B1), .C1(C1), .OUT_VALID(ov2), .DATA_OUT(d2), .OVF(of2));

   logic        ov [3];
   logic [23:0] dout [3];
   logic        ovf [3];
   assign ov[0] = ov0;  assign ov[1] = ov1;  assign ov[2] = ov2;
   assign dout[0] = d0; assign dout[1] = {8'h00, d1}; assign dout[2] = d2;
   assign ovf[0] = of0; assign ovf[1] = of1; assign ovf[2] = of2;

   typedef struct packed {
      logic r, v, m, f, l;
      logic [7:0] a, b, c;
   } beat_t;

   typedef struct {
      int          inst;
      int          due;
      logic [23:0] d;
      logic        o;
   } exp_t;

   exp_t        pq[$];
   longint      acc_m [3];
   bit          fo_m [3];
   logic        exp_v [3];
   logic [23:0] exp_d [3];
   logic        exp_o [3];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   function automatic beat_t mk(input logic r, v, m, f, l, input logic [7:0] a, b, c);
      beat_t x;
      x.r = r; x.v = v; x.m = m; x.f = f; x.l = l; x.a = a; x.b = b; x.c = c;
      return x;
   endfunction

   // Reference model: config 0 = unsigned/24, 1 = unsigned/16, 2 = signed/24.
   function automatic void model_beat(input int i, input beat_t b);
      int w; bit sg; bit sat;
      longint ea, eb, ec, prod, sum, mx, mn, mask;
      exp_t e;
      w = (i == 1) ? 16 : 24;
      sg = (i == 2);
      sat = 1'b0;
      if (sg) begin
         ea = $signed(b.a); eb = $signed(b.b); ec = $signed(b.c);
      end else begin
         ea = b.a; eb = b.b; ec = b.c;
      end
      prod = ea * eb;
      mask = (longint'(1) << w) - 1;
      e.inst = i;
      e.due = cyc + 3;
      if (!b.m) begin
         e.d = 24'((prod + ec) & mask);
         e.o = 1'b0;
         pq.push_back(e);
      end else begin
         sum = (b.f ? longint'(0) : acc_m[i]) + prod;
         if (sg) begin
            mx = (longint'(1) << (w - 1)) - 1;
            mn = -(longint'(1) << (w - 1));
         end else begin
            mx = mask;
            mn = 0;
         end
         if (sum > mx) begin
            sum = mx; sat = 1'b1;
         end else if (sum < mn) begin
            sum = mn; sat = 1'b1;
         end
         acc_m[i] = sum;
         fo_m[i] = (b.f ? 1'b0 : fo_m[i]) | sat;
         if (b.l) begin
            e.d = 24'(sum & mask);
            e.o = fo_m[i];
            pq.push_back(e);
         end
      end
   endfunction

   // Drive one beat, advance one edge, update the model, settle past the edge.
   task automatic step(input beat_t b);
      exp_t keep[$];
      RST = b.r; IN_VALID = b.v; MODE = b.m; FIRST = b.f; LAST = b.l;
      A1 = b.a; B1 = b.b; C1 = b.c;
      @(posedge C);
      cyc++;
      if (b.r) begin
         pq.delete();
         for (int i = 0; i < 3; i++) begin
            acc_m[i] = 0; fo_m[i] = 1'b0;
            exp_v[i] = 1'b0; exp_d[i] = 24'd0; exp_o[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 3; i++) exp_v[i] = 1'b0;
         foreach (pq[j]) begin
            if (pq[j].due == cyc) begin
               exp_v[pq[j].inst] = 1'b1;
               exp_d[pq[j].inst] = pq[j].d;
               exp_o[pq[j].inst] = pq[j].o;
            end else begin
               keep.push_back(pq[j]);
            end
         end
         pq = keep;
         if (b.v) for (int i = 0; i < 3; i++) model_beat(i, b);
      end
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 4; k++) begin
         step(mk(k < 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 8'd9, 8'd9));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], dout[i], ovf[i]} !== {exp_v[i], exp_d[i], exp_o[i]}) begin
               errors++;
               $display("FAIL reset cfg%0d cyc=%0d got v=%0b d=%0h o=%0b want v=%0b d=%0h o=%0b",
                        i, cyc, ov[i], dout[i], ovf[i], exp_v[i], exp_d[i], exp_o[i]);
            end
            if (k == 1) begin
               checks++;
               if ({ov[i], dout[i], ovf[i]} !== 26'd0) begin
                  errors++;
                  $display("FAIL reset_zero cfg%0d got v=%0b d=%0h o=%0b want all 0", i, ov[i], dout[i], ovf[i]);
               end
            end
         end
      end
   endtask

   task automatic test_mode0();
      beat_t bt[$];
      bt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd4, 8'd5));
      for (int k = 0; k < bt.size() + 4; k++) begin
         step(k < bt.size() ? bt[k] : mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], dout[i], ovf[i]} !== {exp_v[i], exp_d[i], exp_o[i]}) begin
               errors++;
               $display("FAIL mode0 cfg%0d cyc=%0d got v=%0b d=%0h o=%0b want v=%0b d=%0h o=%0b",
                        i, cyc, ov[i], dout[i], ovf[i], exp_v[i], exp_d[i], exp_o[i]);
            end
         end
         if (k == 3 || k == 4) begin
            checks++;
            if (ov[0] !== (k == 3) || dout[0] !== 24'd17 || ovf[0] !== 1'b0) begin
               errors++;
               $display("FAIL mode0_latency k=%0d got v=%0b d=%0d o=%0b want v=%0b d=17 o=0",
                        k, ov[0], dout[0], ovf[0], (k == 3));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      beat_t bt[$];
      bt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255));
      bt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 8'd1, 8'd0));
      for (int k = 0; k < bt.size() + 4; k++) begin
         step(k < bt.size() ? bt[k] : mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], dout[i], ovf[i]} !== {exp_v[i], exp_d[i], exp_o[i]}) begin
               errors++;
               $display("FAIL back_to_back cfg%0d cyc=%0d got v=%0b d=%0h o=%0b want v=%0b d=%0h o=%0b",
                        i, cyc, ov[i], dout[i], ovf[i], exp_v[i], exp_d[i], exp_o[i]);
            end
         end
         if (k == 3 || k == 4) begin
            checks++;
            if (ov[0] !== 1'b1 || dout[0] !== ((k == 3) ? 24'd65280 : 24'd1)) begin
               errors++;
               $display("FAIL back_to_back_const k=%0d got v=%0b d=%0d want v=1 d=%0d",
                        k, ov[0], dout[0], (k == 3) ? 65280 : 1);
            end
         end
      end
   endtask

   task automatic test_frame();
      beat_t bt[$];
      bt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 8'd3, 8'd99));
      bt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4, 8'd5, 8'd99));
      bt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd50, 8'd50, 8'd0));
      bt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 8'd1));
      bt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd6, 8'd7, 8'd99));
      for (int k = 0; k < bt.size() + 4; k++) begin
         step(k < bt.size() ? bt[k] : mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], dout[i], ovf[i]} !== {exp_v[i], exp_d[i], exp_o[i]}) begin
               errors++;
               $display("FAIL frame cfg%0d cyc=%0d got v=%0b d=%0h o=%0b want v=%0b d=%0h o=%0b",
                        i, cyc, ov[i], dout[i], ovf[i], exp_v[i], exp_d[i], exp_o[i]);
            end
         end
         if (k == 6 || k == 7) begin
            checks++;
            if (ov[0] !== 1'b1 || dout[0] !== ((k == 6) ? 24'd2 : 24'd68) || ovf[0] !== 1'b0) begin
               errors++;
               $display("FAIL frame_const k=%0d got v=%0b d=%0d o=%0b want v=1 d=%0d o=0",
                        k, ov[0], dout[0], ovf[0], (k == 6) ? 2 : 68);
            end
         end
      end
   endtask

   task automatic test_saturate();
      beat_t bt[$];
      bt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd255, 8'd255, 8'd0));
      bt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd255, 8'd255, 8'd0));
      bt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd10, 8'd10, 8'd0));
      for (int k = 0; k < bt.size() + 4; k++) begin
         step(k < bt.size() ? bt[k] : mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], dout[i], ovf[i]} !== {exp_v[i], exp_d[i], exp_o[i]}) begin
               errors++;
               $display("FAIL saturate cfg%0d cyc=%0d got v=%0b d=%0h o=%0b want v=%0b d=%0h o=%0b",
                        i, cyc, ov[i], dout[i], ovf[i], exp_v[i], exp_d[i], exp_o[i]);
            end
         end
         if (k == 4 || k == 5) begin
            checks++;
            if (ov[1] !== 1'b1 || dout[1] !== ((k == 4) ? 24'd65535 : 24'd100) || ovf[1] !== (k == 4)) begin
               errors++;
               $display("FAIL saturate_acc16 k=%0d got v=%0b d=%0d o=%0b want v=1 d=%0d o=%0b",
                        k, ov[1], dout[1], ovf[1], (k == 4) ? 65535 : 100, (k == 4));
            end
         end
      end
   endtask

   task automatic test_signed();
      beat_t bt[$];
      bt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD, 8'h04, 8'hFF));
      for (int k = 0; k < bt.size() + 3; k++) begin
         step(k < bt.size() ? bt[k] : mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], dout[i], ovf[i]} !== {exp_v[i], exp_d[i], exp_o[i]}) begin
               errors++;
               $display("FAIL signed cfg%0d cyc=%0d got v=%0b d=%0h o=%0b want v=%0b d=%0h o=%0b",
                        i, cyc, ov[i], dout[i], ovf[i], exp_v[i], exp_d[i], exp_o[i]);
            end
         end
      end
      checks++;
      if (ov[2] !== 1'b1 || dout[2] !== 24'hFFFFF3 || ovf[2] !== 1'b0) begin
         errors++;
         $display("FAIL signed_const got v=%0b d=%0h o=%0b want v=1 d=fffff3 o=0", ov[2], dout[2], ovf[2]);
      end
   endtask

   task automatic test_signed_sat();
      for (int k = 0; k < 1208; k++) begin
         if (k < 600)
            step(mk(1'b0, 1'b1, 1'b1, k == 0, k == 599, 8'h80, 8'h7F, 8'd0));
         else if (k >= 604 && k < 1204)
            step(mk(1'b0, 1'b1, 1'b1, k == 604, k == 1203, 8'h80, 8'h80, 8'd0));
         else
            step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], dout[i], ovf[i]} !== {exp_v[i], exp_d[i], exp_o[i]}) begin
               errors++;
               $display("FAIL signed_sat cfg%0d cyc=%0d got v=%0b d=%0h o=%0b want v=%0b d=%0h o=%0b",
                        i, cyc, ov[i], dout[i], ovf[i], exp_v[i], exp_d[i], exp_o[i]);
            end
         end
         if (k == 602 || k == 1206) begin
            checks++;
            if (ov[2] !== 1'b1 || ovf[2] !== 1'b1 || dout[2] !== ((k == 602) ? 24'h800000 : 24'h7FFFFF)) begin
               errors++;
               $display("FAIL signed_sat_clamp k=%0d got v=%0b d=%0h o=%0b want v=1 d=%0h o=1",
                        k, ov[2], dout[2], ovf[2], (k == 602) ? 24'h800000 : 24'h7FFFFF);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      beat_t bt[$];
      bt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2, 8'd0));
      bt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 8'd4, 8'd0));
      bt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
      bt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 8'd5, 8'd0));
      for (int k = 0; k < bt.size() + 4; k++) begin
         step(k < bt.size() ? bt[k] : mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], dout[i], ovf[i]} !== {exp_v[i], exp_d[i], exp_o[i]}) begin
               errors++;
               $display("FAIL reset_midframe cfg%0d cyc=%0d got v=%0b d=%0h o=%0b want v=%0b d=%0h o=%0b",
                        i, cyc, ov[i], dout[i], ovf[i], exp_v[i], exp_d[i], exp_o[i]);
            end
         end
         if (k == 2 || k == 4 || k == 6) begin
            checks++;
            if (ov[0] !== (k == 6) || dout[0] !== ((k == 6) ? 24'd25 : 24'd0)) begin
               errors++;
               $display("FAIL reset_midframe_const k=%0d got v=%0b d=%0d want v=%0b d=%0d",
                        k, ov[0], dout[0], (k == 6), (k == 6) ? 25 : 0);
            end
         end
      end
   endtask

   function automatic logic [7:0] pick8();
      case ($urandom_range(0, 5))
         0: return 8'hFF;
         1: return 8'h80;
         2: return 8'h7F;
         3: return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic test_random();
      beat_t b;
      for (int k = 0; k < 500; k++) begin
         b = mk($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, pick8(), pick8(), pick8());
         step(b);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], dout[i], ovf[i]} !== {exp_v[i], exp_d[i], exp_o[i]}) begin
               errors++;
               $display("FAIL random cfg%0d cyc=%0d got v=%0b d=%0h o=%0b want v=%0b d=%0h o=%0b",
                        i, cyc, ov[i], dout[i], ovf[i], exp_v[i], exp_d[i], exp_o[i]);
            end
         end
      end
   endtask

   initial begin
      RST = 1'b1; IN_VALID = 1'b0; MODE = 1'b0; FIRST = 1'b0; LAST = 1'b0;
      A1 = 8'd0; B1 = 8'd0; C1 = 8'd0;
      for (int i = 0; i < 3; i++) begin
         acc_m[i] = 0; fo_m[i] = 1'b0; exp_v[i] = 1'b0; exp_d[i] = 24'd0; exp_o[i] = 1'b0;
      end
      test_reset();
      test_mode0();
      test_back_to_back();
      test_frame();
      test_saturate();
      test_signed();
      test_signed_sat();
      test_reset_midframe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
